// File: rtl/mem_pkg.sv
// mem_pkg -- shared encodings for the memory access sequencer.
//   SZ_BYTE / SZ_HALF / SZ_WORD : request size codes (2'b11 is handled as word)
//   state_t                     : sequencer states IDLE, RD_WAIT, WRITE, DONE
//   is_misaligned()             : alignment rule, only built with MEM_ALIGN_CHECK_EN
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

`ifdef MEM_ALIGN_CHECK_EN
    // Bytes are always aligned; halves need addr[0]=0; word and size 11 need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == SZ_BYTE)
            return 1'b0;
        else if (size == SZ_HALF)
            return addr_lo[0];
        else
            return (addr_lo != 2'b00);
    endfunction
`endif

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if -- request and memory bus bundle of the access sequencer.
//   req_*     : request handshake from the control unit
//   mem_*     : word-wide data memory port
//   mdr_out   : memory data register toward the load-size stage
//   done      : completion pulse
//   misalign  : present only when MEM_ALIGN_CHECK_EN is defined
// Modports: slave = the sequencer, master = the requester/memory side.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mdr_out;
    logic        done;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_wr, mem_wdata, mdr_out, done
`ifdef MEM_ALIGN_CHECK_EN
        , output misalign
`endif
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_wr, mem_wdata, mdr_out, done
`ifdef MEM_ALIGN_CHECK_EN
        , input misalign
`endif
    );

endinterface

// File: rtl/store_merge.sv
// store_merge -- combinational lane merge for sub-word stores.
//   size      : request size code
//   wdata     : latched store data (byte/half taken from the low lanes)
//   merge     : upper 24 bits of the word read back before the write
//   mem_wdata : full word to write
module store_merge
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:8] merge,
    output logic [31:0] mem_wdata
);

    always_comb begin
        mem_wdata = wdata;
        case (size)
            SZ_BYTE: mem_wdata = {merge[31:8], wdata[7:0]};
            SZ_HALF: mem_wdata = {merge[31:16], wdata[15:0]};
            default: mem_wdata = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- multicycle load/store sequencer with read-modify-write
// for byte and halfword stores, owning the memory data register.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : mem_access_ctrl_if.slave (request, memory port, mdr_out, done)
// Parameter MEM_LATENCY (1..15): cycles from address to valid mem_rdata.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned requests complete at once
// with a misalign pulse and never touch memory.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    mem_access_ctrl_if.slave bus
);

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [31:8] merge_q;
    logic [31:0] mdr_q;
    logic [31:0] merged;
    logic        accept;
    logic        rd_last;
    logic        req_is_word;
    logic        mis_now;

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;
    assign mis_now = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    // Low address bits play no part when alignment checking is off.
    logic unused_addr_lo;
    assign mis_now        = 1'b0;
    assign unused_addr_lo = ^bus.req_addr[1:0];
`endif

    assign accept      = bus.req_valid && (state_q == IDLE);
    assign rd_last     = (state_q == RD_WAIT) && (cnt_q == LAT);
    assign req_is_word = (bus.req_size != SZ_BYTE) && (bus.req_size != SZ_HALF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (mis_now)
                        state_d = DONE;
                    else if (bus.req_write && req_is_word)
                        state_d = WRITE;
                    else
                        state_d = RD_WAIT;
                end
            end
            RD_WAIT: if (rd_last) state_d = write_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter runs 1..LAT while in RD_WAIT and sits at 0 everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            mdr_q   <= '0;
        end else begin
            cnt_q <= (state_d == RD_WAIT) ? cnt_q + 4'd1 : 4'd0;
            if (accept) begin
                write_q <= bus.req_write;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr[31:2];
                wdata_q <= bus.req_wdata;
            end
            if (rd_last) begin
                if (write_q)
                    merge_q <= bus.mem_rdata[31:8];
                else
                    mdr_q <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mis_q <= 1'b0;
        else if (accept)
            mis_q <= mis_now;
    end
    assign bus.misalign = (state_q == DONE) && mis_q;
`endif

    store_merge u_merge (
        .size      (size_q),
        .wdata     (wdata_q),
        .merge     (merge_q),
        .mem_wdata (merged)
    );

    // All bus outputs decode from state so reset clears them immediately.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_wr    = (state_q == WRITE);
    assign bus.done      = (state_q == DONE);
    assign bus.mem_addr  = (state_q != IDLE) ? {addr_q, 2'b00} : 32'd0;
    assign bus.mem_wdata = (state_q == WRITE) ? merged : 32'd0;
    assign bus.mdr_out   = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int L = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_LATENCY(L)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Physical memory: 16 words, preload port plus DUT write port.
    logic [31:0] phys [16];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (pre_we)
            phys[pre_idx] <= pre_data;
        else if (bus.mem_wr === 1'b1)
            phys[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    // Read data is only valid in the L-th cycle after the address appears.
    int age;
    always @(posedge clk or posedge rst) begin
        if (rst)
            age <= 0;
        else if (bus.req_ready === 1'b1)
            age <= 0;
        else
            age <= age + 1;
    end
    assign bus.mem_rdata = (age == L - 1) ? phys[bus.mem_addr[5:2]] : 32'hA5A5_5A5A;

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] ref_mdr;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b00) return 1'b0;
        if (size == 2'b01) return ALIGN_EN && (addr % 2 != 0);
        return ALIGN_EN && (addr % 4 != 0);
    endfunction

    task automatic do_access(input bit wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int n, idx, done_k, wr_k, wr_cnt, mis_cnt, exp_done, exp_wr, exp_rd;
        logic [31:0] wr_data, mdr_done, old, exp_wdata, waddr;
        logic rdy_after, done_after, mis_done;
        bit mis;
        idx   = int'(addr[5:2]);
        waddr = addr & 32'hFFFF_FFFC;
        mis   = model_mis(size, addr);
        old   = ref_mem[idx];
        exp_wdata = 32'd0;
        if (mis) begin
            exp_rd = 0; exp_wr = 0; exp_done = 1;
        end else if (!wr) begin
            exp_rd = L; exp_wr = 0; exp_done = L + 1; ref_mdr = old;
        end else if (size == 2'b00) begin
            exp_rd = L; exp_wr = L + 1; exp_done = L + 2;
            exp_wdata = (old & 32'hFFFF_FF00) | (wdata & 32'h0000_00FF);
        end else if (size == 2'b01) begin
            exp_rd = L; exp_wr = L + 1; exp_done = L + 2;
            exp_wdata = (old & 32'hFFFF_0000) | (wdata & 32'h0000_FFFF);
        end else begin
            exp_rd = 0; exp_wr = 1; exp_done = 2; exp_wdata = wdata;
        end
        if (exp_wr != 0) ref_mem[idx] = exp_wdata;

        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 32'(bus.req_ready), 32'd1);

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        done_k = 0; wr_k = 0; wr_cnt = 0; mis_cnt = 0;
        wr_data = 32'd0; mdr_done = 32'hxxxx_xxxx;
        rdy_after = 1'b0; done_after = 1'b1; mis_done = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.mem_wr === 1'b1) begin
                wr_cnt++; wr_k = k; wr_data = bus.mem_wdata;
                chk("wr_addr", bus.mem_addr, waddr);
            end
            if (k <= exp_rd) chk("rd_addr", bus.mem_addr, waddr);
            if (done_k == 0 && bus.done === 1'b1) begin
                done_k = k;
                mdr_done = bus.mdr_out;
`ifdef MEM_ALIGN_CHECK_EN
                mis_done = bus.misalign;
`endif
            end
`ifdef MEM_ALIGN_CHECK_EN
            if (bus.misalign === 1'b1) mis_cnt++;
`endif
            if (done_k == 0) chk("ready_busy", 32'(bus.req_ready), 32'd0);
            if (done_k != 0 && k == done_k + 1) begin
                rdy_after  = bus.req_ready;
                done_after = bus.done;
                break;
            end
            @(posedge clk); #1;
        end

        chk("done_cycle", 32'(done_k), 32'(exp_done));
        chk("wr_count", 32'(wr_cnt), (exp_wr != 0) ? 32'd1 : 32'd0);
        if (exp_wr != 0) begin
            chk("wr_cycle", 32'(wr_k), 32'(exp_wr));
            chk("wr_data", wr_data, exp_wdata);
        end
        chk("mdr_out", mdr_done, ref_mdr);
        chk("ready_after_done", 32'(rdy_after), 32'd1);
        chk("done_one_cycle", 32'(done_after), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_at_done", 32'(mis_done), 32'(mis));
        chk("misalign_pulses", 32'(mis_cnt), 32'(mis));
`else
        if (mis_done || mis_cnt != 0) chk("misalign_absent", 32'd1, 32'd0);
`endif
    endtask

    initial begin
        int wr_seen;
        logic [31:0] v;
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'd0;
        pre_we = 1'b1; pre_idx = 4'd0; pre_data = 32'd0;
        ref_mdr = 32'd0;

        // Preload memory while reset holds the sequencer (req_valid stays high).
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            if (i == 0) v = 32'h0BAD_F00D;
            if (i == 4) v = 32'hDEAD_BEEF;
            if (i == 8) v = 32'h1122_3344;
            pre_idx = 4'(i); pre_data = v; ref_mem[i] = v;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;

        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mdr_out", bus.mdr_out, 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
`endif
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(bus.req_ready), 32'd1);

        // Directed cases
        do_access(1'b0, 2'b10, 32'h0000_0010, 32'd0);
        chk("load_deadbeef", bus.mdr_out, 32'hDEAD_BEEF);
        do_access(1'b1, 2'b00, 32'h0000_0020, 32'h1234_56AB);
        do_access(1'b1, 2'b10, 32'h0000_0020, 32'hAAAA_BBBB);
        do_access(1'b1, 2'b01, 32'h0000_0020, 32'hFFFF_CAFE);
        do_access(1'b0, 2'b10, 32'h0000_0020, 32'd0);
        chk("load_aaaacafe", bus.mdr_out, 32'hAAAA_CAFE);
        do_access(1'b1, 2'b10, 32'h0000_0030, 32'h0000_0055);

        // Byte store aborted by reset during RD_WAIT.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h0000_0030;
        bus.req_wdata = 32'hFFFF_FF77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_busy", 32'(bus.req_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("abort_mdr", bus.mdr_out, 32'd0);
        ref_mdr = 32'd0;
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
            if (bus.mem_wr === 1'b1) wr_seen++;
        end
        chk("abort_no_write", 32'(wr_seen), 32'd0);
        chk("abort_idle", 32'(bus.req_ready), 32'd1);
        do_access(1'b0, 2'b10, 32'h0000_0030, 32'd0);
        chk("load_after_abort", bus.mdr_out, 32'h0000_0055);

        // Unaligned word load: misaligned completion or aligned word 0.
        do_access(1'b0, 2'b10, 32'h0000_0002, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            do_access(1'($urandom), 2'($urandom_range(0, 3)),
                      32'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 16; i++) chk("mem_final", phys[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle memory access sequencer between the control unit and the word-wide data memory. It accepts one load or store request at a time, waits out the memory latency, and performs read-modify-write for byte and halfword stores. It also owns the memory data register, whose output feeds the load-size stage, which extracts the byte, half or word.

## Interface
Parameters:
- MEM_LATENCY, default 2: cycles from address presentation to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the byte or half is taken from the low lanes.
- mem_addr  output  32  word address {addr_q[31:2],2'b00}.
- mem_wr  output  1  memory write strobe, one cycle per store.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  memory read data.
- mdr_out  output  32  memory data register, feeds the load-size stage.
- done  output  1  one-cycle completion pulse.
- misalign  output  1  only with MEM_ALIGN_CHECK_EN; one-cycle pulse coincident with done.

## Operation
- States: IDLE, RD_WAIT, WRITE, DONE.
- On accept, latch req_write, req_size, req_addr and req_wdata into *_q registers.
- Next state after accept:
  - Load (any size): RD_WAIT.
  - Word store: WRITE.
  - Byte or half store: RD_WAIT.
- RD_WAIT:
  - Latency counter counts 1..MEM_LATENCY.
  - On the edge ending the final count, mem_rdata is captured.
  - Load: mem_rdata goes into mdr_out; next state DONE.
  - Byte/half store: mem_rdata goes into an internal merge register; next state WRITE.
- WRITE:
  - mem_wr = 1 for exactly one cycle.
  - mem_wdata is one of:
    - word: wdata_q;
    - half: {merge[31:16], wdata_q[15:0]};
    - byte: {merge[31:8], wdata_q[7:0]}.
  - Next state DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- mdr_out changes only on load capture. Stores never modify it.
- mem_addr is driven from addr_q in every non-IDLE state.
- mem_wr is decoded from state, so an asynchronous reset deasserts it immediately.
- Reset values:
  - state IDLE, so req_ready = 1;
  - mdr_out, mem_addr, mem_wdata, the merge register and the counter all 0;
  - mem_wr, done and misalign all 0.
- Reset mid-operation aborts the access. No write is issued after reset assertion, and the request is lost.
- req_valid in any non-IDLE state is ignored; the requester holds it.

## Timing
In the sequences below, T is the cycle in which the request is accepted and L = MEM_LATENCY.
- Load:
  - RD_WAIT occupies T+1..T+L.
  - mdr_out is valid from T+L+1.
  - done is high in T+L+1.
  - req_ready returns high in T+L+2.
- Word store: mem_wr in T+1, done in T+2.
- Byte/half store: RD_WAIT T+1..T+L, mem_wr in T+L+1, done in T+L+2.
- Back-to-back: the next request can be accepted at the earliest in the cycle after done.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A half with req_addr[0]=1, or a word or size-11 access with req_addr[1:0]≠0, is accepted.
  - It goes straight to DONE: no memory read or write, mdr_out unchanged.
  - done and misalign pulse together in T+1.
- Not defined:
  - misalign port absent.
  - Address low bits are ignored for all sizes.
  - The access proceeds on the aligned word.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state encoding IDLE/RD_WAIT/WRITE/DONE.
- Sub-module store_merge (combinational):
  - inputs size, wdata_q, merge word;
  - output mem_wdata.
  - This keeps the lane logic symmetrical with the load-size stage.

## Test plan
- Reset with req_valid high: req_ready=1, mdr_out=0, mem_wr=0, done=0; no accept while reset is high.
- Word load, L=2, addr 0x0000_0010, memory word 0xDEAD_BEEF:
  - mem_addr=0x10 in T+1..T+2;
  - mdr_out=0xDEAD_BEEF and done=1 in T+3.
- Byte store, addr 0x20, wdata 0x1234_56AB, memory 0x1122_3344: one mem_wr with mem_wdata=0x1122_33AB in T+3, done in T+4.
- Half store of 0xFFFF_CAFE onto 0xAAAA_BBBB: mem_wdata=0xAAAA_CAFE; a following word load of 0x20 returns 0xAAAA_CAFE in mdr_out.
- Word store 0x0000_0055 (mem_wr in T+1, done in T+2), then reset asserted mid-way through a subsequent byte store's RD_WAIT: mem_wr never pulses, state IDLE, mdr_out=0, and the next accepted load completes normally.
- With MEM_ALIGN_CHECK_EN, word load at 0x0000_0002: done and misalign high in T+1, mem_wr=0, mdr_out unchanged. Without the macro, the same request returns the word at 0x0.
